tx_core_self_contained: RTL and testbench

- Byte-serial UART/ISO7816-3 character transmitter; the transmit-side counterpart of the self-contained receive core.
- Contains its own clock divider and bit-clock counter, a one-deep holding register and a frame state machine.
- Drives the start bit, 8 data bits, parity and 1 or 2 stop bits on `serialOut`.
- Sits beside the receive core in the ISO7816 master; both share the `clkPerCycle`/`clocksPerBit` configuration.

---
 rtl/tx_core_pkg.sv | 18 +
 rtl/tx_bit_clock_counter.sv | 36 +++
 rtl/tx_core_self_contained.sv | 176 +++++++++++++++++
 tb/tb_tx_core_self_contained.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_core_pkg.sv
// Shared types for the byte-serial UART/ISO7816-3 transmit core.
// The GUARD state is only entered when ISO7816_TX_RETRY_EN is defined.
package tx_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        GUARD
    } txState_t;

    localparam int BIT_INDEX_WIDTH = 3;
    localparam logic [BIT_INDEX_WIDTH-1:0] LAST_DATA_INDEX = 3'd7;

endpackage

// File: rtl/tx_bit_clock_counter.sv
// Clock divider plus bit-clock counter; both are held at zero while disabled.
// bitEnd marks the last tick of a bit, midBit the tick at clocksPerBit>>1.
module tx_bit_clock_counter #(
    parameter int DIVIDER_WIDTH       = 1,
    parameter int CLOCK_PER_BIT_WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [DIVIDER_WIDTH-1:0]       clkPerCycle,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    output logic                           tick,
    output logic                           bitEnd,
    output logic                           midBit
);

    logic [DIVIDER_WIDTH-1:0]       r_divCount;
    logic [CLOCK_PER_BIT_WIDTH-1:0] r_bitCount;

    assign tick   = enable && (r_divCount == clkPerCycle);
    assign bitEnd = tick && (r_bitCount == clocksPerBit);
    assign midBit = tick && (r_bitCount == (clocksPerBit >> 1));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_divCount <= '0;
            r_bitCount <= '0;
        end else begin
            r_divCount <= tick ? '0 : r_divCount + DIVIDER_WIDTH'(1);
            if (tick) begin
                r_bitCount <= bitEnd ? '0 : r_bitCount + CLOCK_PER_BIT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tx_core_self_contained.sv
// Byte-serial UART/ISO7816-3 transmitter: holding register, frame FSM, own bit clock.
// Define ISO7816_TX_RETRY_EN to enable error-signal detection and byte retransmission.
module tx_core_self_contained
    import tx_core_pkg::*;
#(
    parameter int   DIVIDER_WIDTH       = 1,
    parameter int   CLOCK_PER_BIT_WIDTH = 13,
    parameter logic START_BIT           = 1'b0,
    parameter logic STOP_BIT1           = 1'b1,
    parameter logic STOP_BIT2           = 1'b1,
    parameter int   MAX_RETRIES         = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     dataIn,
    input  logic                           loadDataIn,
    input  logic [DIVIDER_WIDTH-1:0]       clkPerCycle,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic                           stopBit2,
    input  logic                           oddParity,
    input  logic                           msbFirst,
    input  logic                           serialIn,
    output logic                           serialOut,
    output logic                           full,
    output logic                           run,
    output logic                           endOfTx,
    output logic                           errorFlag
);

    txState_t                   r_state;
    logic [7:0]                 r_holdReg;
    logic [7:0]                 r_txByte;
    logic [BIT_INDEX_WIDTH-1:0] r_bitIndex;
    logic                       r_full;
    logic                       r_run;
    logic                       r_serialOut;
    logic                       r_stopBit2;
    logic                       r_oddParity;
    logic                       r_msbFirst;

    logic w_unusedTick;
    logic w_bitEnd;
    logic w_midBit;
    logic w_lastStop;
    logic w_errPending;
    logic w_frameDone;
    logic w_startNew;
    logic w_lineLevel;

    tx_bit_clock_counter #(
        .DIVIDER_WIDTH      (DIVIDER_WIDTH),
        .CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH)
    ) u_bitClock (
        .clk         (clk),
        .reset       (reset),
        .enable      (r_run),
        .clkPerCycle (clkPerCycle),
        .clocksPerBit(clocksPerBit),
        .tick        (w_unusedTick),
        .bitEnd      (w_bitEnd),
        .midBit      (w_midBit)
    );

`ifdef ISO7816_TX_RETRY_EN
    localparam int RETRY_WIDTH = $clog2(MAX_RETRIES + 1);

    logic                   r_errSeen;
    logic                   r_errorFlag;
    logic [RETRY_WIDTH-1:0] r_retryCount;
    logic                   w_errSample;

    // A receiver signals a parity error by pulling the line low mid-way through STOP1.
    assign w_errSample  = (r_state == STOP1) && w_midBit && !serialIn;
    assign w_errPending = r_errSeen || w_errSample;
    assign errorFlag    = r_errorFlag;
`else
    logic w_unusedRetry;

    assign w_unusedRetry = serialIn ^ w_midBit ^ (MAX_RETRIES == 0);
    assign w_errPending  = 1'b0;
    assign errorFlag     = 1'b0;
`endif

    assign w_lastStop  = (r_state == STOP2) || ((r_state == STOP1) && !r_stopBit2);
    assign w_frameDone = w_bitEnd && w_lastStop && !w_errPending;
    assign w_startNew  = r_full && ((r_state == IDLE) || w_frameDone);

    always_comb begin
        w_lineLevel = STOP_BIT1;
        case (r_state)
            START:   w_lineLevel = START_BIT;
            DATA:    w_lineLevel = r_msbFirst ? r_txByte[LAST_DATA_INDEX - r_bitIndex]
                                              : r_txByte[r_bitIndex];
            PARITY:  w_lineLevel = (^r_txByte) ^ r_oddParity;
            STOP2:   w_lineLevel = STOP_BIT2;
            default: w_lineLevel = STOP_BIT1;
        endcase
    end

    // Later assignments win: frame end and frame start override the per-state steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_holdReg   <= '0;
            r_txByte    <= '0;
            r_bitIndex  <= '0;
            r_full      <= 1'b0;
            r_run       <= 1'b0;
            r_serialOut <= STOP_BIT1;
            r_stopBit2  <= 1'b0;
            r_oddParity <= 1'b0;
            r_msbFirst  <= 1'b0;
`ifdef ISO7816_TX_RETRY_EN
            r_errSeen    <= 1'b0;
            r_errorFlag  <= 1'b0;
            r_retryCount <= '0;
`endif
        end else begin
            r_serialOut <= w_lineLevel;
            if (loadDataIn && !r_full) begin
                r_holdReg <= dataIn;
                r_full    <= 1'b1;
            end
            case (r_state)
                START: if (w_bitEnd) begin
                    r_state    <= DATA;
                    r_bitIndex <= '0;
                end
                DATA: if (w_bitEnd) begin
                    if (r_bitIndex == LAST_DATA_INDEX) r_state <= PARITY;
                    else r_bitIndex <= r_bitIndex + BIT_INDEX_WIDTH'(1);
                end
                PARITY: if (w_bitEnd) r_state <= STOP1;
                STOP1:  if (w_bitEnd && r_stopBit2) r_state <= STOP2;
                default: ;
            endcase
            if (w_frameDone && !r_full) begin
                r_state <= IDLE;
                r_run   <= 1'b0;
            end
`ifdef ISO7816_TX_RETRY_EN
            if (w_errSample) r_errSeen <= 1'b1;
            if (w_bitEnd && w_lastStop && w_errPending) r_state <= GUARD;
            if (w_frameDone) r_retryCount <= '0;
            if ((r_state == GUARD) && w_bitEnd) begin
                r_errSeen <= 1'b0;
                if (r_retryCount == RETRY_WIDTH'(MAX_RETRIES)) begin
                    r_errorFlag  <= 1'b1;
                    r_retryCount <= '0;
                    r_state      <= IDLE;
                    r_run        <= 1'b0;
                end else begin
                    r_retryCount <= r_retryCount + RETRY_WIDTH'(1);
                    r_state      <= START;
                end
            end
            if (w_startNew) r_errSeen <= 1'b0;
`endif
            if (w_startNew) begin
                r_state     <= START;
                r_run       <= 1'b1;
                r_full      <= 1'b0;
                r_txByte    <= r_holdReg;
                r_stopBit2  <= stopBit2;
                r_oddParity <= oddParity;
                r_msbFirst  <= msbFirst;
            end
        end
    end

    assign serialOut = r_serialOut;
    assign full      = r_full;
    assign run       = r_run;
    assign endOfTx   = w_frameDone;

endmodule

// File: tb/tb_tx_core_self_contained.sv
// Scoreboard bench for tx_core_self_contained: expected line frames are queued at load
// time and compared bit by bit at mid-bit. Retry scenarios need ISO7816_TX_RETRY_EN.
module tb_tx_core_self_contained;

    localparam int DW = 1;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    dataIn;
    logic          loadDataIn;
    logic [DW-1:0] clkPerCycle;
    logic [CW-1:0] clocksPerBit;
    logic          stopBit2;
    logic          oddParity;
    logic          msbFirst;
    logic          serialIn;
    logic          serialOut;
    logic          full;
    logic          run;
    logic          endOfTx;
    logic          errorFlag;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          period;
        bit          inject;
    } frame_t;

    frame_t sb[$];
    int     gapLog[$];
    int     errors   = 0;
    int     checks   = 0;
    int     eotCount = 0;
    bit     monBusy  = 1'b0;

    tx_core_self_contained dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn      (dataIn),
        .loadDataIn  (loadDataIn),
        .clkPerCycle (clkPerCycle),
        .clocksPerBit(clocksPerBit),
        .stopBit2    (stopBit2),
        .oddParity   (oddParity),
        .msbFirst    (msbFirst),
        .serialIn    (serialIn),
        .serialOut   (serialOut),
        .full        (full),
        .run         (run),
        .endOfTx     (endOfTx),
        .errorFlag   (errorFlag)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference frame built from the current bench configuration.
    function automatic frame_t buildFrame(input logic [7:0] d, input bit inject);
        frame_t f;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = msbFirst ? d[7-i] : d[i];
        f.bits[9]  = (^d) ^ oddParity;
        f.bits[10] = 1'b1;
        f.bits[11] = 1'b1;
        f.nbits    = stopBit2 ? 12 : 11;
        f.period   = (int'(clocksPerBit) + 1) * (int'(clkPerCycle) + 1);
        f.inject   = inject;
        return f;
    endfunction

    task automatic applyStimulus(input logic [7:0] d);
        @(posedge clk);
        #1;
        dataIn     = d;
        loadDataIn = 1'b1;
        @(posedge clk);
        #1;
        loadDataIn = 1'b0;
    endtask

    task automatic setConfig(input int cpc, input int cpb, input bit msb, input bit odd, input bit two);
        clkPerCycle  = DW'(cpc);
        clocksPerBit = CW'(cpb);
        msbFirst     = msb;
        oddParity    = odd;
        stopBit2     = two;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || monBusy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(n < 3000), 32'd1);
    endtask

    // Line monitor: detects start bits, samples each bit mid-way, drives error signals.
    initial begin
        int     idle = 0;
        frame_t f;
        serialIn = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                idle = 0;
                continue;
            end
            if (serialOut !== 1'b0) begin
                idle++;
                continue;
            end
            if (sb.size() == 0) begin
                checkOutput("unexpectedStart", 32'(serialOut), 32'd1);
                for (int k = 0; k < 500 && serialOut === 1'b0; k++) @(negedge clk);
                continue;
            end
            f       = sb.pop_front();
            monBusy = 1'b1;
            gapLog.push_back(idle);
            idle = 0;
            for (int c = 0; c < f.nbits * f.period; c++) begin
                if (c > 0) @(negedge clk);
                if (reset !== 1'b0) break;
                serialIn = (f.inject && c >= 10 * f.period && c < 11 * f.period) ? 1'b0 : 1'b1;
                if (c % f.period == f.period / 2)
                    checkOutput($sformatf("bit%0d", c / f.period), 32'(serialOut),
                                32'(f.bits[c / f.period]));
            end
            serialIn = 1'b1;
            monBusy  = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (endOfTx === 1'b1) eotCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int eBase;
        reset      = 1'b1;
        loadDataIn = 1'b0;
        dataIn     = 8'h00;
        setConfig(0, 3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstSerialOut", 32'(serialOut), 32'd1);
        checkOutput("rstFull", 32'(full), 32'd0);
        checkOutput("rstRun", 32'(run), 32'd0);
        checkOutput("rstEndOfTx", 32'(endOfTx), 32'd0);
        checkOutput("rstErrorFlag", 32'(errorFlag), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] basic frame 0xA5");
        eBase = eotCount;
        sb.push_back(buildFrame(8'hA5, 1'b0));
        applyStimulus(8'hA5);
        @(negedge clk);
        checkOutput("loadFull", 32'(full), 32'd1);
        checkOutput("loadRun", 32'(run), 32'd0);
        @(negedge clk);
        checkOutput("startRun", 32'(run), 32'd1);
        checkOutput("startFull", 32'(full), 32'd0);
        checkOutput("preStartLine", 32'(serialOut), 32'd1);
        @(negedge clk);
        checkOutput("latencyLine", 32'(serialOut), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (endOfTx !== 1'b1 && n < 200);
        checkOutput("eotTiming", 32'(n), 32'(11 * 4 - 2));
        @(negedge clk);
        checkOutput("runFall", 32'(run), 32'd0);
        waitIdle("basicDone");
        checkOutput("basicEotCount", 32'(eotCount - eBase), 32'd1);

        $display("[TB] msb first, odd parity, two stop bits, 0x3B");
        setConfig(1, 3, 1'b1, 1'b1, 1'b1);
        eBase = eotCount;
        sb.push_back(buildFrame(8'h3B, 1'b0));
        applyStimulus(8'h3B);
        waitIdle("msbDone");
        checkOutput("msbEotCount", 32'(eotCount - eBase), 32'd1);

        $display("[TB] back-to-back with overrun");
        setConfig(0, 3, 1'b0, 1'b0, 1'b0);
        gapLog.delete();
        eBase = eotCount;
        sb.push_back(buildFrame(8'h00, 1'b0));
        applyStimulus(8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2bFirstTaken", 32'(full), 32'd0);
        sb.push_back(buildFrame(8'hFF, 1'b0));
        applyStimulus(8'hFF);
        @(negedge clk);
        checkOutput("b2bSecondFull", 32'(full), 32'd1);
        applyStimulus(8'h33);
        @(negedge clk);
        checkOutput("overrunFull", 32'(full), 32'd1);
        waitIdle("b2bDone");
        checkOutput("b2bFrames", 32'(gapLog.size()), 32'd2);
        checkOutput("b2bGap", 32'(gapLog.size() >= 2 ? gapLog[1] : -1), 32'd0);
        repeat (60) @(negedge clk);
        checkOutput("b2bEotCount", 32'(eotCount - eBase), 32'd2);
        checkOutput("b2bIdleRun", 32'(run), 32'd0);
        checkOutput("b2bIdleFull", 32'(full), 32'd0);

        $display("[TB] reset during data bit 4");
        sb.push_back(buildFrame(8'hA5, 1'b0));
        applyStimulus(8'hA5);
        repeat (22) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abortLine", 32'(serialOut), 32'd1);
        checkOutput("abortRun", 32'(run), 32'd0);
        checkOutput("abortFull", 32'(full), 32'd0);
        sb.delete();
        sb.push_back(buildFrame(8'h5A, 1'b0));
        applyStimulus(8'h5A);
        waitIdle("afterResetDone");

`ifdef ISO7816_TX_RETRY_EN
        $display("[TB] retry exhausted on 0x55");
        eBase = eotCount;
        for (int i = 0; i < 5; i++) sb.push_back(buildFrame(8'h55, 1'b1));
        applyStimulus(8'h55);
        waitIdle("retryAllDone");
        repeat (20) @(negedge clk);
        checkOutput("retryErrorFlag", 32'(errorFlag), 32'd1);
        checkOutput("retryNoEot", 32'(eotCount - eBase), 32'd0);
        checkOutput("retryRun", 32'(run), 32'd0);
        pulseReset();
        @(negedge clk);
        checkOutput("retryFlagCleared", 32'(errorFlag), 32'd0);

        $display("[TB] single error then success on 0x55");
        eBase = eotCount;
        sb.push_back(buildFrame(8'h55, 1'b1));
        sb.push_back(buildFrame(8'h55, 1'b0));
        applyStimulus(8'h55);
        waitIdle("retryOnceDone");
        repeat (20) @(negedge clk);
        checkOutput("retryOnceEot", 32'(eotCount - eBase), 32'd1);
        checkOutput("retryOnceFlag", 32'(errorFlag), 32'd0);
`else
        $display("[TB] error signal ignored without retry support");
        eBase = eotCount;
        sb.push_back(buildFrame(8'h55, 1'b1));
        applyStimulus(8'h55);
        waitIdle("noRetryDone");
        repeat (30) @(negedge clk);
        checkOutput("noRetryEot", 32'(eotCount - eBase), 32'd1);
        checkOutput("noRetryFlag", 32'(errorFlag), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
